// File: rtl/pcie_trans_pkg.sv
// pcie_trans_pkg
//   Shared definitions for the PCIe transaction datapath:
//   - DATA_W     : default word width (bits [5:4] class/dest tag, [3:0] payload)
//   - dest_e     : destination FIFO identifier (DEST_D0 / DEST_D1)
//   - occ_e      : occupancy state of the 2-entry drain buffer
//   - occ_count  : converts an occupancy state to a word count
package pcie_trans_pkg;

  localparam int DATA_W = 6;

  typedef enum logic {
    DEST_D0 = 1'b0,
    DEST_D1 = 1'b1
  } dest_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e s);
    logic [1:0] n;
    case (s)
      OCC_ONE:  n = 2'd1;
      OCC_FULL: n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf
//   Two-entry {data, dest} buffer that absorbs the one-cycle FIFO read
//   latency in front of a valid/ready output stream.
//   Ports:
//     clk, reset_L            clock, asynchronous active-low reset
//     cap_valid/data/dest     word landing from an in-flight pop (capture)
//     out_ready               consumer ready
//     out_valid/data/dest     buffer head presented to the consumer
//     occ                     current occupancy (EMPTY / ONE / FULL)
//   The producer must never capture into a FULL buffer unless the head is
//   leaving in the same cycle; the arbiter guarantees this.
module drain_skid_buf
  import pcie_trans_pkg::*;
#(
  parameter int DATA_W = pcie_trans_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  input  dest_e             cap_dest,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output dest_e             out_dest,
  output occ_e              occ
);

  occ_e              occ_reg, occ_next;
  logic [DATA_W-1:0] head_data_reg, head_data_next;
  dest_e             head_dest_reg, head_dest_next;
  logic [DATA_W-1:0] tail_data_reg, tail_data_next;
  dest_e             tail_dest_reg, tail_dest_next;
  logic              hs;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      occ_reg       <= OCC_EMPTY;
      head_data_reg <= '0;
      head_dest_reg <= DEST_D0;
      tail_data_reg <= '0;
      tail_dest_reg <= DEST_D0;
    end else begin
      occ_reg       <= occ_next;
      head_data_reg <= head_data_next;
      head_dest_reg <= head_dest_next;
      tail_data_reg <= tail_data_next;
      tail_dest_reg <= tail_dest_next;
    end
  end

  always_comb begin
    occ_next       = occ_reg;
    head_data_next = head_data_reg;
    head_dest_next = head_dest_reg;
    tail_data_next = tail_data_reg;
    tail_dest_next = tail_dest_reg;
    hs             = (occ_reg != OCC_EMPTY) && out_ready;

    case (occ_reg)
      OCC_EMPTY: begin
        if (cap_valid) begin
          head_data_next = cap_data;
          head_dest_next = cap_dest;
          occ_next       = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({cap_valid, hs})
          2'b10: begin
            tail_data_next = cap_data;
            tail_dest_next = cap_dest;
            occ_next       = OCC_FULL;
          end
          2'b01: occ_next = OCC_EMPTY;
          2'b11: begin
            // head leaves and the new word becomes head directly
            head_data_next = cap_data;
            head_dest_next = cap_dest;
          end
          default: ;
        endcase
      end
      OCC_FULL: begin
        if (hs) begin
          head_data_next = tail_data_reg;
          head_dest_next = tail_dest_reg;
          if (cap_valid) begin
            tail_data_next = cap_data;
            tail_dest_next = cap_dest;
          end else begin
            occ_next = OCC_ONE;
          end
        end
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  assign out_valid = (occ_reg != OCC_EMPTY);
  assign out_data  = head_data_reg;
  assign out_dest  = head_dest_reg;
  assign occ       = occ_reg;

endmodule

// File: rtl/pcie_drain_arbiter.sv
// pcie_drain_arbiter
//   Drains destination FIFOs D0/D1 with round-robin arbitration into a single
//   valid/ready stream tagged with its source destination.
//   Ports:
//     clk, reset_L              clock, asynchronous active-low reset
//     init                      synchronous clear of counters and RR pointer
//     empty_D0/D1, data_D0/D1   FIFO status and read data (data one cycle after pop)
//     pop_D0/D1                 combinational pop strobes, at most one high
//     out_ready/valid/data/dest output stream; out_dest 0 = D0, 1 = D1
//     idle_out                  registered: FIFOs empty, nothing in flight, buffer empty
//     cnt_D0/D1                 delivered-word counts per destination
//   Build option: define PCIE_DRAIN_COUNTERS_EN to include the delivered-word
//   counters; otherwise cnt_D0/cnt_D1 are tied to zero.
module pcie_drain_arbiter
  import pcie_trans_pkg::*;
#(
  parameter int DATA_W = pcie_trans_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_D0,
  input  logic [DATA_W-1:0] data_D1,
  output logic              pop_D0,
  output logic              pop_D1,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_dest,
  output logic              idle_out,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1
);

  logic              inflight_reg;
  dest_e             inflight_dest_reg;
  dest_e             last_reg, last_next;
  logic              idle_reg;

  occ_e              occ;
  dest_e             buf_dest;
  logic              hs;
  logic              room;
  logic              any_ready;
  logic              grant;
  dest_e             sel;
  logic [DATA_W-1:0] cap_data;

  assign hs = out_valid & out_ready;

  // Words already committed (buffered + in flight) minus the one leaving
  // this cycle must stay below the buffer depth for another pop to fit.
  assign room = ({1'b0, occ_count(occ)} + {2'b00, inflight_reg})
                < (3'd2 + {2'b00, hs});

  assign any_ready = !empty_D0 || !empty_D1;

  always_comb begin
    sel = DEST_D0;
    if (!empty_D0 && !empty_D1) begin
      sel = (last_reg == DEST_D1) ? DEST_D0 : DEST_D1;
    end else if (!empty_D0) begin
      sel = DEST_D0;
    end else if (!empty_D1) begin
      sel = DEST_D1;
    end
  end

  // reset_L in the grant keeps the pop strobes low for the whole reset period
  assign grant  = room && any_ready && reset_L;
  assign pop_D0 = grant && (sel == DEST_D0);
  assign pop_D1 = grant && (sel == DEST_D1);

  always_comb begin
    last_next = last_reg;
    if (init) begin
      last_next = DEST_D1;
    end else if (grant) begin
      last_next = sel;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      inflight_reg      <= 1'b0;
      inflight_dest_reg <= DEST_D0;
      last_reg          <= DEST_D1;
      idle_reg          <= 1'b1;
    end else begin
      inflight_reg      <= grant;
      inflight_dest_reg <= sel;
      last_reg          <= last_next;
      idle_reg          <= empty_D0 && empty_D1 && !inflight_reg && (occ == OCC_EMPTY);
    end
  end

  // The FIFO read data belongs to the pop issued last cycle.
  assign cap_data = (inflight_dest_reg == DEST_D1) ? data_D1 : data_D0;

  drain_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset_L   (reset_L),
    .cap_valid (inflight_reg),
    .cap_data  (cap_data),
    .cap_dest  (inflight_dest_reg),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_dest  (buf_dest),
    .occ       (occ)
  );

  assign out_dest = buf_dest;
  assign idle_out = idle_reg;

`ifdef PCIE_DRAIN_COUNTERS_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        cnt_reg <= '0;
      end else if (init) begin
        cnt_reg <= '0;
      end else if (hs && (out_dest == (gi == 1))) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
  assign cnt_D0 = g_cnt[0].cnt_reg;
  assign cnt_D1 = g_cnt[1].cnt_reg;
`else
  assign cnt_D0 = '0;
  assign cnt_D1 = '0;
`endif

endmodule

// File: doc/pcie_drain_arbiter.md
# pcie_drain_arbiter

Downstream drain stage of the PCIe transaction datapath. Pops the two destination FIFOs (D0, D1) with round-robin arbitration, absorbs their one-cycle read latency in a 2-entry output buffer, and presents a single valid/ready stream tagged with its destination. It replaces testbench-driven `pop_D0`/`pop_D1` in the integrated transaction layer and reports idle status and per-destination delivered-word counts.

## Interface
Parameters:
- `DATA_W`, 6, word width (bits [5:4] = class/dest tag, [3:0] payload; carried opaque)
- `CNT_W`, 8, width of per-destination delivered-word counters

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_L`  in  1  asynchronous, active-low reset
- `init`  in  1  synchronous clear of counters and RR pointer
- `empty_D0`, `empty_D1`  in  1  destination FIFO empty flags; reflect pops up to the previous edge
- `data_D0`, `data_D1`  in  DATA_W  FIFO read data, valid the cycle after the corresponding pop
- `pop_D0`, `pop_D1`  out  1  FIFO pop strobes (combinational, at most one high per cycle)
- `out_ready`  in  1  consumer ready
- `out_valid`  out  1  output word valid
- `out_data`  out  DATA_W  output word (buffer head)
- `out_dest`  out  1  source of `out_data`: 0 = D0, 1 = D1
- `idle_out`  out  1  both FIFOs empty, no pop in flight, buffer empty
- `cnt_D0`, `cnt_D1`  out  CNT_W  delivered-word counts

## Operation
- Buffer: 2 entries {data, dest}; occupancy FSM EMPTY -> ONE -> FULL. Capture (in-flight pop landing) increments; handshake (`out_valid & out_ready`) decrements; both in same cycle: occupancy unchanged, FIFO order preserved.
- In-flight register: `inflight` (1 bit) + `inflight_dest`, set in the cycle after a pop.
- Pop permitted when `occ + inflight - hs < 2`, where `hs` = current handshake. Never pops an empty FIFO.
- Arbitration: if both non-empty, grant the one not granted last (RR pointer, resets to "last = D1" so D0 wins first). If one non-empty, grant it; pointer updates on every grant.
- Counters: `cnt_Dx` increments on handshake with `out_dest = x`; wrap modulo 2^CNT_W.
- `init`: clears counters and RR pointer next edge; buffer and in-flight data untouched (no word loss).
- `idle_out` registered: high when both empties high, `inflight` = 0, occupancy EMPTY.

## Timing
- Reset values: `pop_D0/D1` = 0 (while `reset_L` low), `out_valid` = 0, `out_data` = 0, `out_dest` = 0, `cnt_D0/D1` = 0, `idle_out` = 1, occupancy EMPTY, `inflight` = 0.
- Latency: pop in cycle t -> data sampled at end of t+1 -> `out_valid` in t+2 (if buffer empty).
- Sustained throughput: 1 word/cycle with `out_ready` held high.
- `out_ready` low: at most 2 pops beyond the buffer head outstanding; pops stop once buffer FULL or FULL-after-capture; no overflow, no drop.
- `out_data`/`out_dest` stable while `out_valid & !out_ready`.
- Reset asserted mid-operation: all state cleared immediately, in-flight word discarded.

## Configuration
- `PCIE_DRAIN_COUNTERS_EN` defined: counter logic present as described.
- Undefined: counter registers omitted; `cnt_D0`/`cnt_D1` ports remain, tied to 0; all other behaviour identical.

## Structure
- Shared package `pcie_trans_pkg`: `DATA_W` constant, destination enum (`DEST_D0`, `DEST_D1`), buffer-occupancy state enum.
- One sub-module: `drain_skid_buf` (2-entry {data, dest} buffer with occupancy FSM, capture and handshake ports). Arbiter, in-flight tracking and counters stay in the top.

## Test plan
- Reset then D0 holds 0x1B, 0x0D, D1 empty, `out_ready`=1 -> pops at t, t+1; out 0x1B (dest 0) at t+2, 0x0D at t+3; `idle_out` returns 1; `cnt_D0`=2.
- Both FIFOs non-empty (D0: 0x03, 0x31; D1: 0x1A, 0x0C) -> pop order D0, D1, D0, D1; outputs 0x03/0, 0x1A/1, 0x31/0, 0x0C/1 on consecutive cycles.
- `out_ready`=0 with D0 holding 5 words -> exactly 2 pops, `out_valid`=1 with first word stable; raising `out_ready` drains all 5 in order, none lost or duplicated.
- `out_ready` toggling every cycle with both FIFOs full -> no pop while `empty_Dx`=1, occupancy never exceeds 2, output sequence matches RR reference model.
- `init` pulsed with 1 word in flight and `cnt_D0`=3 -> counters read 0 next cycle, in-flight word still delivered and counted (`cnt`=1).
- `reset_L` dropped with buffer FULL -> `out_valid`=0, `pop_*`=0, counters 0 immediately; after release first grant goes to D0.
